// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
//
// Arbitrates load-use hazards, EX-resolved branches, data-memory busy and
// exceptions / exception return. It drives per-stage stall/flush and the PC
// redirect, and holds the EPC / cause state.
// Per-cycle priority: exception > eret > mem_busy > branch > ld_hazard.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   ld_hazard             load-use hazard detected in ID
//   ex_en, br_taken       EX holds a valid instruction / it is a taken branch
//   br_addr               branch target
//   mem_busy              data memory not ready, whole pipe holds
//   exp_req/code/pc       exception raised by the MEM-stage instruction
//   eret_req              exception return reached MEM
//   *_stall, *_flush      per pipeline register hold / bubble
//   pc_load, new_pc       PC redirect (combinational)
//   epc, exp_cause        saved exception PC and cause (registered)
//   in_exc                handler-mode flag (registered)
//
// Optional: define PIPE_CTRL_PERF_EN to add the perf_stall_cnt / perf_flush_cnt
// counters (cycles with any stall / cycles with pc_load).

module pipe_ctrl #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    EXC_VECTOR = ADDR_W'(32'h0000_0040),
    parameter int unsigned          CODE_W     = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_hazard,
    input  logic              ex_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              mem_busy,
    input  logic              exp_req,
    input  logic [CODE_W-1:0] exp_code,
    input  logic [ADDR_W-1:0] exp_pc,
    input  logic              eret_req,
    output logic              if_stall,
    output logic              id_stall,
    output logic              ex_stall,
    output logic              mem_stall,
    output logic              if_flush,
    output logic              id_flush,
    output logic              ex_flush,
    output logic              mem_flush,
    output logic              pc_load,
    output logic [ADDR_W-1:0] new_pc,
    output logic [ADDR_W-1:0] epc,
    output logic [CODE_W-1:0] exp_cause,
    output logic              in_exc
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {StRun, StExc, StHandler, StRet} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   epc_q, epc_d;
    logic [CODE_W-1:0]   cause_q, cause_d;
    logic                in_exc_q, in_exc_d;

    // Bit 3 = IF, 2 = ID, 1 = EX, 0 = MEM.
    logic [3:0]          stall_v;
    logic [3:0]          flush_v;

    // Exceptions and erets are only accepted in the steady states.
    logic                steady;
    assign steady = (state_q == StRun) || (state_q == StHandler);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StRun;
            epc_q    <= '0;
            cause_q  <= '0;
            in_exc_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            epc_q    <= epc_d;
            cause_q  <= cause_d;
            in_exc_q <= in_exc_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        in_exc_d = in_exc_q;
        case (state_q)
            StRun, StHandler: begin
                if (exp_req) begin
                    // A nested exception in the handler overwrites epc.
                    state_d = StExc;
                    epc_d   = exp_pc;
                    cause_d = exp_code;
                end else if ((state_q == StHandler) && eret_req) begin
                    state_d = StRet;
                end
            end
            StExc: begin
                state_d  = StHandler;
                in_exc_d = 1'b1;
            end
            StRet: begin
                state_d  = StRun;
                in_exc_d = 1'b0;
            end
            default: state_d = StRun;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        stall_v = 4'b0000;
        flush_v = 4'b0000;
        pc_load = 1'b0;
        new_pc  = '0;
        if (reset) begin
            if (!steady) begin
                // EXC / RET redirect cycle: squash the two younger stages
                // fetched down the old path; all requests are ignored.
                flush_v = 4'b1100;
            end else if (exp_req) begin
                flush_v = 4'b1111;
                pc_load = 1'b1;
                new_pc  = EXC_VECTOR;
            end else if ((state_q == StHandler) && eret_req) begin
                flush_v = 4'b1111;
                pc_load = 1'b1;
                new_pc  = epc_q;
            end else if (mem_busy) begin
                // Branch and hazard sources are frozen by this stall and
                // get re-evaluated once memory is ready.
                stall_v = 4'b1111;
            end else if (br_taken && ex_en) begin
                // The younger hazarding instruction is killed, so the
                // branch wins over ld_hazard.
                flush_v = 4'b1100;
                pc_load = 1'b1;
                new_pc  = br_addr;
            end else if (ld_hazard) begin
                // Hold IF and the instruction in ID; id_flush inserts the
                // bubble into ID/EX, so EX and MEM keep advancing.
                stall_v = 4'b1100;
                flush_v = 4'b0100;
            end
        end
    end

    assign if_stall  = stall_v[3];
    assign id_stall  = stall_v[2];
    assign ex_stall  = stall_v[1];
    assign mem_stall = stall_v[0];
    assign if_flush  = flush_v[3];
    assign id_flush  = flush_v[2];
    assign ex_flush  = flush_v[1];
    assign mem_flush = flush_v[0];

    assign epc       = epc_q;
    assign exp_cause = cause_q;
    assign in_exc    = in_exc_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    always_comb begin
        perf_stall_d = perf_stall_q + {31'd0, |stall_v};
        perf_flush_d = perf_flush_q + {31'd0, pc_load};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: table-driven RUN-state vectors,
// hand-written multi-cycle sequences, then randomized stimulus against a
// behavioural model.
module tb_pipe_ctrl;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned CODE_W  = 3;
    localparam logic [31:0] EXC_VEC = 32'h0000_0040;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              ld_hazard = 1'b0;
    logic              ex_en = 1'b0;
    logic              br_taken = 1'b0;
    logic [ADDR_W-1:0] br_addr = '0;
    logic              mem_busy = 1'b0;
    logic              exp_req = 1'b0;
    logic [CODE_W-1:0] exp_code = '0;
    logic [ADDR_W-1:0] exp_pc = '0;
    logic              eret_req = 1'b0;
    logic              if_stall, id_stall, ex_stall, mem_stall;
    logic              if_flush, id_flush, ex_flush, mem_flush;
    logic              pc_load;
    logic [ADDR_W-1:0] new_pc;
    logic [ADDR_W-1:0] epc;
    logic [CODE_W-1:0] exp_cause;
    logic              in_exc;
`ifdef PIPE_CTRL_PERF_EN
    logic [31:0]       perf_stall_cnt, perf_flush_cnt;
    logic [31:0]       m_stall_cnt = 0, m_flush_cnt = 0;
`endif

    pipe_ctrl #(
        .ADDR_W     (ADDR_W),
        .EXC_VECTOR (EXC_VEC),
        .CODE_W     (CODE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ld_hazard (ld_hazard),
        .ex_en     (ex_en),
        .br_taken  (br_taken),
        .br_addr   (br_addr),
        .mem_busy  (mem_busy),
        .exp_req   (exp_req),
        .exp_code  (exp_code),
        .exp_pc    (exp_pc),
        .eret_req  (eret_req),
        .if_stall  (if_stall),
        .id_stall  (id_stall),
        .ex_stall  (ex_stall),
        .mem_stall (mem_stall),
        .if_flush  (if_flush),
        .id_flush  (id_flush),
        .ex_flush  (ex_flush),
        .mem_flush (mem_flush),
        .pc_load   (pc_load),
        .new_pc    (new_pc),
        .epc       (epc),
        .exp_cause (exp_cause),
        .in_exc    (in_exc)
`ifdef PIPE_CTRL_PERF_EN
        ,
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    // stall/flush: bit 3 = IF ... bit 0 = MEM.
    typedef struct packed {
        logic [3:0]  stall;
        logic [3:0]  flush;
        logic        pc_load;
        logic [31:0] new_pc;
    } outs_t;

    outs_t dut_o;
    assign dut_o = {if_stall, id_stall, ex_stall, mem_stall,
                    if_flush, id_flush, ex_flush, mem_flush, pc_load, new_pc};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // redirect: 0 none, 1 exception-entry cycle, 2 return cycle.
    int          m_redirect = 0;
    logic        m_in_exc = 1'b0;
    logic [31:0] m_epc = '0;
    logic [2:0]  m_cause = '0;

    function automatic outs_t model_out();
        outs_t o = '0;
        if (!reset) return o;
        if (m_redirect != 0) begin
            o.flush = 4'b1100;
        end else if (exp_req) begin
            o.flush = 4'b1111; o.pc_load = 1'b1; o.new_pc = EXC_VEC;
        end else if (m_in_exc && eret_req) begin
            o.flush = 4'b1111; o.pc_load = 1'b1; o.new_pc = m_epc;
        end else if (mem_busy) begin
            o.stall = 4'b1111;
        end else if (br_taken && ex_en) begin
            o.flush = 4'b1100; o.pc_load = 1'b1; o.new_pc = br_addr;
        end else if (ld_hazard) begin
            o.stall = 4'b1100; o.flush = 4'b0100;
        end
        return o;
    endfunction

    task automatic model_step();
`ifdef PIPE_CTRL_PERF_EN
        outs_t o = model_out();
        m_stall_cnt = m_stall_cnt + {31'd0, |o.stall};
        m_flush_cnt = m_flush_cnt + {31'd0, o.pc_load};
`endif
        if (m_redirect == 1) begin
            m_in_exc = 1'b1; m_redirect = 0;
        end else if (m_redirect == 2) begin
            m_in_exc = 1'b0; m_redirect = 0;
        end else if (exp_req) begin
            m_epc = exp_pc; m_cause = exp_code; m_redirect = 1;
        end else if (m_in_exc && eret_req) begin
            m_redirect = 2;
        end
    endtask

    task automatic model_reset();
        m_redirect = 0; m_in_exc = 1'b0; m_epc = '0; m_cause = '0;
`ifdef PIPE_CTRL_PERF_EN
        m_stall_cnt = 0; m_flush_cnt = 0;
`endif
    endtask

    // ---------------- helpers ----------------
    task automatic set_in(input logic ld, input logic en, input logic br, input logic [31:0] addr,
                          input logic mb, input logic xr, input logic [2:0] xc,
                          input logic [31:0] xpc, input logic er);
        ld_hazard = ld; ex_en = en; br_taken = br; br_addr = addr; mem_busy = mb;
        exp_req = xr; exp_code = xc; exp_pc = xpc; eret_req = er;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 32'h0, 0, 0, 3'd0, 32'h0, 0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic outs_t mk(input logic [3:0] st, input logic [3:0] fl, input logic pl,
                                 input logic [31:0] pc);
        outs_t o;
        o.stall = st; o.flush = fl; o.pc_load = pl; o.new_pc = pc;
        return o;
    endfunction

    task automatic do_reset();
        idle_in();
        reset = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        model_reset();
        #1;
    endtask

    typedef struct {
        logic        ld, en, br, mb, er;
        logic [31:0] addr;
        outs_t       exp;
    } vec_t;

    task automatic rand_cycle();
        outs_t e;
        ld_hazard = ($urandom_range(0, 2) == 0);
        ex_en     = ($urandom_range(0, 3) != 0);
        br_taken  = ($urandom_range(0, 2) == 0);
        br_addr   = $urandom;
        mem_busy  = ($urandom_range(0, 3) == 0);
        exp_req   = ($urandom_range(0, 9) == 0);
        exp_code  = 3'($urandom_range(0, 7));
        exp_pc    = $urandom;
        eret_req  = ($urandom_range(0, 2) == 0);
        #1;
        e = model_out();
        chk("rand_out", 64'(dut_o), 64'(e));
        chk("rand_regs", 64'({in_exc, exp_cause, epc}), 64'({m_in_exc, m_cause, m_epc}));
`ifdef PIPE_CTRL_PERF_EN
        chk("rand_perf", {perf_stall_cnt, perf_flush_cnt}, {m_stall_cnt, m_flush_cnt});
`endif
        model_step();
        next_cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vt[8];
        @(negedge clk);

        // 1. reset held, then released with idle inputs
        idle_in();
        eret_req = 1'b1;
        exp_req  = 1'b1;
        #1;
        chk("reset_held_out", 64'(dut_o), 64'(0));
        do_reset();
        chk("reset_out", 64'(dut_o), 64'(0));
        chk("reset_regs", 64'({in_exc, exp_cause, epc}), 64'(0));

        // Table: one cycle each, all in RUN state.
        vt[0] = '{ld:0, en:0, br:0, mb:0, er:0, addr:32'h0,       exp:mk(4'h0, 4'h0, 0, 32'h0)};
        vt[1] = '{ld:1, en:0, br:0, mb:0, er:0, addr:32'h0,       exp:mk(4'hC, 4'h4, 0, 32'h0)};
        vt[2] = '{ld:0, en:0, br:0, mb:0, er:0, addr:32'h0,       exp:mk(4'h0, 4'h0, 0, 32'h0)};
        vt[3] = '{ld:1, en:1, br:1, mb:0, er:0, addr:32'h1234,    exp:mk(4'h0, 4'hC, 1, 32'h1234)};
        vt[4] = '{ld:1, en:0, br:1, mb:0, er:0, addr:32'h5678,    exp:mk(4'hC, 4'h4, 0, 32'h0)};
        vt[5] = '{ld:1, en:1, br:1, mb:1, er:0, addr:32'h9ABC,    exp:mk(4'hF, 4'h0, 0, 32'h0)};
        vt[6] = '{ld:0, en:0, br:0, mb:0, er:1, addr:32'h0,       exp:mk(4'h0, 4'h0, 0, 32'h0)};
        vt[7] = '{ld:0, en:1, br:1, mb:0, er:1, addr:32'hABC0,    exp:mk(4'h0, 4'hC, 1, 32'hABC0)};
        for (int i = 0; i < 8; i++) begin
            set_in(vt[i].ld, vt[i].en, vt[i].br, vt[i].addr, vt[i].mb, 0, 3'd0, 32'h0, vt[i].er);
            #1;
            chk($sformatf("vec%0d", i), 64'(dut_o), 64'(vt[i].exp));
            next_cycle();
        end
        chk("vec_regs", 64'({in_exc, exp_cause, epc}), 64'(0));

        // 4. mem_busy for 3 cycles defers a branch
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 32'h2000, 1, 0, 3'd0, 32'h0, 0);
            #1;
            chk($sformatf("busy%0d", i), 64'(dut_o), 64'(mk(4'hF, 4'h0, 0, 32'h0)));
            next_cycle();
        end
        mem_busy = 1'b0;
        #1;
        chk("busy_release", 64'(dut_o), 64'(mk(4'h0, 4'hC, 1, 32'h2000)));
        next_cycle();

        // 5. exception during mem_busy, handler, eret
        set_in(0, 1, 1, 32'h3000, 1, 1, 3'd2, 32'h100, 0);
        #1;
        chk("exc_entry", 64'(dut_o), 64'(mk(4'h0, 4'hF, 1, EXC_VEC)));
        chk("exc_entry_epc", 64'(epc), 64'(0));
        next_cycle();
        // EXC cycle: new requests must be ignored
        set_in(1, 1, 1, 32'h3000, 1, 1, 3'd6, 32'h777, 1);
        #1;
        chk("exc_cycle", 64'(dut_o), 64'(mk(4'h0, 4'hC, 0, 32'h0)));
        chk("exc_cycle_regs", 64'({in_exc, exp_cause, epc}), 64'({1'b0, 3'd2, 32'h100}));
        next_cycle();
        idle_in();
        #1;
        chk("handler_regs", 64'({in_exc, exp_cause, epc}), 64'({1'b1, 3'd2, 32'h100}));
        chk("handler_idle", 64'(dut_o), 64'(0));
        next_cycle();
        eret_req = 1'b1;
        #1;
        chk("eret", 64'(dut_o), 64'(mk(4'h0, 4'hF, 1, 32'h100)));
        next_cycle();
        #1;
        chk("ret_cycle", 64'(dut_o), 64'(mk(4'h0, 4'hC, 0, 32'h0)));
        chk("ret_in_exc", 64'(in_exc), 64'(1));
        next_cycle();
        #1;
        chk("after_ret_in_exc", 64'(in_exc), 64'(0));
        chk("after_ret_eret_ignored", 64'(dut_o), 64'(0));
        idle_in();
        next_cycle();

        // 6. nested exception, then asynchronous reset in the EXC cycle
        set_in(0, 0, 0, 32'h0, 0, 1, 3'd5, 32'h300, 0);
        next_cycle();
        idle_in();
        next_cycle();
        set_in(0, 0, 0, 32'h0, 0, 1, 3'd7, 32'h404, 0);
        #1;
        chk("nested_entry", 64'(dut_o), 64'(mk(4'h0, 4'hF, 1, EXC_VEC)));
        next_cycle();
        idle_in();
        #1;
        chk("nested_regs", 64'({in_exc, exp_cause, epc}), 64'({1'b1, 3'd7, 32'h404}));
        #1;
        reset = 1'b0;
        #1;
        chk("async_rst_regs", 64'({in_exc, exp_cause, epc}), 64'(0));
        chk("async_rst_out", 64'(dut_o), 64'(0));
`ifdef PIPE_CTRL_PERF_EN
        chk("async_rst_perf", {perf_stall_cnt, perf_flush_cnt}, 64'(0));
`endif
        next_cycle();
        reset = 1'b1;
        model_reset();
        eret_req = 1'b1;
        #1;
        chk("post_rst_run", 64'(dut_o), 64'(0));
        idle_in();
        next_cycle();

        // Randomized run against the model
        do_reset();
        for (int i = 0; i < 3000; i++) rand_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
